vec_scatter: RTL and testbench

- Vector-to-scalar unpacker in the memory stage.
- On a start pulse it reads one 256-bit vector from vector RAM and writes its 32-bit lanes, one lane per cycle, to consecutive word addresses of the scalar data RAM.
- It is the reverse path of the scalar-to-vector gatherer that feeds the vector RAM, so vector results can be read back by the scalar core or the image port.

---
 rtl/vec_scatter.sv | 109 ++++++++++
 tb/tb_vec_scatter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vec_scatter.sv
// vec_scatter: unpacks one vector RAM word into consecutive scalar RAM words.
//
// Reads one VEC_W-bit vector and writes its WORD_W-bit lanes, one per cycle,
// to consecutive word addresses of the scalar data RAM (lane 0 = low bits).
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   i_start         request pulse, honoured only while idle
//   i_src_addr      vector RAM address, latched on accepted start
//   i_dst_addr      scalar RAM base word address, latched on accepted start
//   i_hold          scalar port busy; stalls the pending lane write
//   o_vec_rd_addr   vector RAM read address (latched source while busy, else 0)
//   i_vec_rd_data   vector RAM read data, valid one cycle after the address
//   o_mem_addr      scalar RAM write address
//   o_mem_data      scalar RAM write data
//   o_mem_write     scalar RAM write enable
//   o_busy          operation in progress
//   o_done          one-cycle completion pulse
module vec_scatter #(
    parameter int VEC_W  = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic              i_hold,
    output logic [ADDR_W-1:0] o_vec_rd_addr,
    input  logic [VEC_W-1:0]  i_vec_rd_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_data,
    output logic              o_mem_write,
    output logic              o_busy,
    output logic              o_done
);
    localparam int LANES = VEC_W / WORD_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES * WORD_W != VEC_W) begin : g_bad_width
        $error("vec_scatter: VEC_W must be a whole multiple of WORD_W");
    end

    typedef enum logic [2:0] {S_IDLE, S_RDREQ, S_CAPTURE, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LW-1:0]     r_lane;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [VEC_W-1:0]  r_buf;
    logic              w_last;
    logic              w_wr;

    assign w_last = r_lane == LW'(LANES - 1);
    assign w_wr   = (r_state == S_WRITE) && !i_hold;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = i_start ? S_RDREQ : S_IDLE;
            S_RDREQ:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_WRITE;
            S_WRITE:   w_next = (w_wr && w_last) ? S_DONE : S_WRITE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // The buffer is loaded only in CAPTURE, so later read-data changes
    // cannot disturb lanes still waiting to be written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_src  <= '0;
            r_dst  <= '0;
            r_buf  <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_src <= i_src_addr;
                r_dst <= i_dst_addr;
            end
            if (r_state == S_CAPTURE) begin
                r_buf  <= i_vec_rd_data;
                r_lane <= '0;
            end
            if (w_wr)
                r_lane <= w_last ? '0 : r_lane + 1'b1;
        end
    end

    // Address and data follow the pending lane even while stalled, so a held
    // write presents stable values until it is accepted.
    assign o_busy        = r_state != S_IDLE;
    assign o_done        = r_state == S_DONE;
    assign o_mem_write   = w_wr;
    assign o_vec_rd_addr = o_busy ? r_src : '0;
    assign o_mem_addr    = (r_state == S_WRITE) ? r_dst + ADDR_W'(r_lane) : '0;
    assign o_mem_data    = (r_state == S_WRITE) ? r_buf[r_lane * WORD_W +: WORD_W] : '0;
endmodule

// File: tb/tb_vec_scatter.sv
// tb_vec_scatter: directed and randomized checks of vec_scatter against a lane-list model.
module tb_vec_scatter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic [15:0]  src_addr = '0;
    logic [15:0]  dst_addr = '0;
    logic [255:0] vec_rd_data = '0;
    logic [15:0]  o_vec_rd_addr;
    logic [15:0]  o_mem_addr;
    logic [31:0]  o_mem_data;
    logic         o_mem_write;
    logic         o_busy;
    logic         o_done;
    int           total = 0;
    int           bad = 0;

    vec_scatter dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(start),
        .i_src_addr(src_addr),
        .i_dst_addr(dst_addr),
        .i_hold(hold),
        .o_vec_rd_addr(o_vec_rd_addr),
        .i_vec_rd_data(vec_rd_data),
        .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data),
        .o_mem_write(o_mem_write),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk(tag, {o_busy, o_done, o_mem_write, o_mem_addr, o_mem_data, o_vec_rd_addr}, '0);
    endtask

    // One transfer, starting in the current (idle) cycle. Cycle c counts from
    // the start edge. The model: the vector presented two cycles after start is
    // the one written; from cycle 3 on, each cycle without hold writes the next
    // lane k to dst+k (mod 2^16); done comes the cycle after the eighth write.
    task automatic run_op(input logic [15:0] src, input logic [15:0] dst,
                          input logic [255:0] vec, input logic [63:0] hold_m,
                          input logic [63:0] start_m, input int rst_at);
        int k;
        int c;
        bit fin;
        bit exp_wr;
        logic [15:0] ea;
        k = 0;
        fin = 0;
        start = 1'b1;
        src_addr = src;
        dst_addr = dst;
        hold = hold_m[0];
        vec_rd_data = rnd();
        check_idle("idle_before_start");
        step();
        for (c = 1; c <= 40 && !fin; c++) begin
            start = start_m[c];
            src_addr = start_m[c] ? ~src : src;
            dst_addr = start_m[c] ? dst ^ 16'h5A5A : dst;
            hold = hold_m[c];
            if (c == 2)
                vec_rd_data = vec;
            else if (c == 4)
                vec_rd_data = '1;
            else
                vec_rd_data = rnd();
            if (c == rst_at) rst_n = 1'b0;
            @(negedge clk);
            exp_wr = (c >= 3) && (k < 8) && !hold;
            chk($sformatf("busy c%0d", c), o_busy, 1'b1);
            chk($sformatf("vec_rd_addr c%0d", c), o_vec_rd_addr, src);
            chk($sformatf("done c%0d", c), o_done, k == 8);
            chk($sformatf("mem_write c%0d", c), o_mem_write, exp_wr);
            if (c >= 3 && k < 8) begin
                ea = 16'((32'(dst) + k) % 65536);
                chk($sformatf("mem_addr lane%0d c%0d", k, c), o_mem_addr, ea);
                chk($sformatf("mem_data lane%0d c%0d", k, c), o_mem_data, vec[k*32 +: 32]);
            end
            if (k == 8) fin = 1;
            if (exp_wr) k++;
            if (c == rst_at) begin
                step();
                rst_n = 1'b1;
                start = 1'b0;
                for (int i = 0; i < 14; i++) begin
                    hold = 1'($urandom);
                    vec_rd_data = rnd();
                    check_idle($sformatf("after_reset cyc%0d", i));
                    step();
                end
                return;
            end
            step();
        end
        start = 1'b0;
    endtask

    logic [255:0] v;
    logic [63:0]  hm;

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check_idle("reset_state");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'h11111111 * (i + 1);
        run_op(16'h0010, 16'h0100, v, 64'($urandom_range(0, 7)), '0, 0);

        run_op(16'h0022, 16'hFFFD, rnd(), 64'($urandom_range(0, 7)), '0, 0);

        run_op(16'h0033, 16'h0200, rnd(), 64'h0E0, '0, 0);

        run_op(16'h0044, 16'h0300, rnd(), '0, 64'h822, 0);
        run_op(16'h0055, 16'h0400, rnd(), '0, '0, 0);

        run_op(16'h0066, 16'h0500, rnd(), '0, '0, 6);
        run_op(16'h0077, 16'h0600, rnd(), '0, '0, 0);

        for (int n = 0; n < 6; n++) begin
            hm = {$urandom, $urandom} & 64'h007F_FFF8;
            run_op(16'($urandom), 16'($urandom), rnd(), hm, '0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
